// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider sharing one align/lock FSM across all channels.
// Optional macro CLK_DIV_GEN_LOCK_HOLD_EN: rewriting a channel with its current D/P keeps lock.
module clk_div_gen #(
    parameter int  NUM_CLOCKS  = 2,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = 5,
    parameter int  LOCK_CYCLES = 64,
    localparam int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1,
    localparam int LCK_W       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_stb,
    output logic                  locked
);

    typedef enum logic [1:0] {
        RESET_S   = 2'd0,
        ALIGN     = 2'd1,
        WAIT_LOCK = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LCK_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]        div_q   [NUM_CLOCKS];
    logic [DIV_W-1:0]        div_d   [NUM_CLOCKS];
    logic [DIV_W-1:0]        phase_q [NUM_CLOCKS];
    logic [DIV_W-1:0]        phase_d [NUM_CLOCKS];
    logic [DIV_W-1:0]        cnt_q   [NUM_CLOCKS];
    logic [DIV_W-1:0]        cnt_d   [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0]   outclk_q, outclk_d;
    logic [NUM_CLOCKS-1:0]   stb_q, stb_d;
    logic                    cfg_fire;
    logic                    chan_ok;
    logic                    realign;
    logic                    run_d;

    assign cfg_ready  = (state_q == WAIT_LOCK) || (state_q == LOCKED);
    assign locked     = (state_q == LOCKED);
    assign outclk     = outclk_q;
    assign outclk_stb = stb_q;

    assign cfg_fire = cfg_valid && cfg_ready;
    // Out-of-range channels are still handshaken, but write nothing and never re-align.
    assign chan_ok  = {1'b0, cfg_chan} < (CH_W + 1)'(NUM_CLOCKS);

`ifdef CLK_DIV_GEN_LOCK_HOLD_EN
    logic same_cfg;

    always_comb begin
        same_cfg = 1'b0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_chan == CH_W'(i)) begin
                same_cfg = (div_q[i] == cfg_div) && (phase_q[i] == cfg_phase);
            end
        end
    end

    assign realign = cfg_fire && chan_ok && !same_cfg;
`else
    assign realign = cfg_fire && chan_ok;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            RESET_S: state_d = ALIGN;
            ALIGN: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
            end
            WAIT_LOCK: begin
                if (realign) begin
                    state_d = ALIGN;
                end else if (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCK_W'(1);
                end
            end
            LOCKED: begin
                if (realign) state_d = ALIGN;
            end
            default: state_d = RESET_S;
        endcase

        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (div_q[i] < DIV_W'(2)) begin
                cnt_d[i] = '0;
            end else if (state_q == ALIGN) begin
                cnt_d[i] = (phase_q[i] >= div_q[i]) ? '0 : phase_q[i];
            end else if (state_q == WAIT_LOCK || state_q == LOCKED) begin
                cnt_d[i] = (cnt_q[i] >= div_q[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
            end

            if (cfg_fire && chan_ok && cfg_chan == CH_W'(i)) begin
                div_d[i]   = cfg_div;
                phase_d[i] = cfg_phase;
            end
        end
    end

    // Outputs are decoded from next-state values so the flops present them glitch-free.
    always_comb begin
        outclk_d = '0;
        stb_d    = '0;
        run_d    = (state_d == WAIT_LOCK) || (state_d == LOCKED);
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            outclk_d[i] = run_d && (div_d[i] >= DIV_W'(2)) && (cnt_d[i] < (div_d[i] >> 1));
            stb_d[i]    = run_d && (div_d[i] >= DIV_W'(2)) && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= RESET_S;
            lock_cnt_q <= '0;
            outclk_q   <= '0;
            stb_q      <= '0;
            // NOTE: the per-channel config arrays are reset too, since reset must restore DEFAULT_DIV.
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            outclk_q   <= outclk_d;
            stb_q      <= stb_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
